// File: rtl/i2c_master_reg_seq_pkg.sv
// ----------------------------------------------------------------------------
// i2c_master_reg_seq_pkg
//   Shared definitions for the I2C register-access sequencer:
//     - state_t  : sequencer states (one per byte command plus IDLE/ESTOP/FIN)
//     - RW_*     : R/W bit appended to the 7-bit slave address
//     - cmd_t    : one byte-controller command (command bits plus din)
//     - issue_cmd: command launched from each issuing state
// ----------------------------------------------------------------------------
package i2c_master_reg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEV,    // start + slave address, write direction
        ST_REG,    // register address byte
        ST_WDAT,   // write data byte, stop attached
        ST_RSTA,   // repeated start + slave address, read direction
        ST_RDAT,   // read one byte, master NACK, stop attached
        ST_ESTOP,  // stop alone after a NACKed byte
        ST_FIN     // one-cycle completion
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic [7:0] din;
    } cmd_t;

    // Command for an issuing state. States that send no byte keep din_prev so
    // din only changes when a new byte actually goes out.
    function automatic cmd_t issue_cmd(
        input state_t     st,
        input logic [6:0] dev,
        input logic [7:0] reg_a,
        input logic [7:0] wd,
        input logic [7:0] din_prev
    );
        cmd_t c;
        c       = '0;
        c.din   = din_prev;
        case (st)
            ST_DEV: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = {dev, RW_WRITE};
            end
            ST_REG: begin
                c.write = 1'b1;
                c.din   = reg_a;
            end
            ST_WDAT: begin
                c.write = 1'b1;
                c.stop  = 1'b1;
                c.din   = wd;
            end
            ST_RSTA: begin
                c.start = 1'b1;
                c.write = 1'b1;
                c.din   = {dev, RW_READ};
            end
            ST_RDAT: begin
                c.read  = 1'b1;
                c.stop  = 1'b1;
            end
            ST_ESTOP: begin
                c.stop  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_master_reg_seq.sv
// ----------------------------------------------------------------------------
// i2c_master_reg_seq
//   Expands a single-register read/write request into the byte-level command
//   sequence of an I2C byte controller and reports the result.
//
//   Host side:
//     req, req_rd, dev_addr, reg_addr, wdata  - request (sampled in IDLE only)
//     busy, done                               - progress / one-cycle end pulse
//     nack_err, al_err                         - error status, held until next req
//     rdata                                    - read result
//   Byte-controller side:
//     start, stop, read, write, ack_in, din    - command (held until cmd_ack)
//     cmd_ack, ack_out, dout, i2c_al           - controller response
//
//   Each command state has two phases tracked by `issued`: the first cycle
//   registers the command, then it waits for cmd_ack. Clearing the command on
//   cmd_ack and re-issuing only from the next state's first cycle leaves a
//   one-cycle gap with all command bits low between commands.
// ----------------------------------------------------------------------------
module i2c_master_reg_seq
    import i2c_master_reg_seq_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    // host request / status
    input  logic       req,
    input  logic       req_rd,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       al_err,
    output logic [7:0] rdata,
    // byte-controller command
    output logic       start,
    output logic       stop,
    output logic       read,
    output logic       write,
    output logic       ack_in,
    output logic [7:0] din,
    // byte-controller response
    input  logic       cmd_ack,
    input  logic       ack_out,
    input  logic [7:0] dout,
    input  logic       i2c_al
);

    state_t     state_q,  state_d;
    logic       issued_q, issued_d;
    cmd_t       cmd_q,    cmd_d;
    logic       ack_in_q;
    logic       rd_q,     rd_d;
    logic [6:0] dev_q,    dev_d;
    logic [7:0] reg_q,    reg_d;
    logic [7:0] wdat_q,   wdat_d;
    logic       nack_q,   nack_d;
    logic       al_q,     al_d;
    logic [7:0] rdata_q,  rdata_d;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        cmd_d    = cmd_q;
        rd_d     = rd_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdat_d   = wdat_q;
        nack_d   = nack_q;
        al_d     = al_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rd_d     = req_rd;
                    dev_d    = dev_addr;
                    reg_d    = reg_addr;
                    wdat_d   = wdata;
                    nack_d   = 1'b0;
                    al_d     = 1'b0;
                    issued_d = 1'b0;
                    state_d  = ST_DEV;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                if (i2c_al) begin
                    // Bus is lost: drop the command, no stop, straight to FIN.
                    // Wins over a simultaneous cmd_ack, so rdata is not touched.
                    cmd_d       = issue_cmd(ST_IDLE, dev_q, reg_q, wdat_q, cmd_q.din);
                    al_d        = 1'b1;
                    issued_d    = 1'b0;
                    state_d     = ST_FIN;
                end else if (!issued_q) begin
                    cmd_d       = issue_cmd(state_q, dev_q, reg_q, wdat_q, cmd_q.din);
                    issued_d    = 1'b1;
                end else if (cmd_ack) begin
                    cmd_d       = issue_cmd(ST_IDLE, dev_q, reg_q, wdat_q, cmd_q.din);
                    issued_d    = 1'b0;
                    case (state_q)
                        ST_DEV: begin
                            nack_d  = ack_out;
                            state_d = ack_out ? ST_ESTOP : ST_REG;
                        end
                        ST_REG: begin
                            nack_d  = ack_out;
                            if (ack_out)
                                state_d = ST_ESTOP;
                            else
                                state_d = rd_q ? ST_RSTA : ST_WDAT;
                        end
                        ST_RSTA: begin
                            nack_d  = ack_out;
                            state_d = ack_out ? ST_ESTOP : ST_RDAT;
                        end
                        ST_WDAT: begin
                            // Stop already went out with this byte.
                            nack_d  = ack_out;
                            state_d = ST_FIN;
                        end
                        ST_RDAT: begin
                            rdata_d = dout;
                            state_d = ST_FIN;
                        end
                        default: begin
                            state_d = ST_FIN;  // ST_ESTOP
                        end
                    endcase
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            issued_q <= 1'b0;
            cmd_q    <= '0;
            ack_in_q <= 1'b0;
            rd_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdat_q   <= '0;
            nack_q   <= 1'b0;
            al_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            cmd_q    <= cmd_d;
            // The single read byte is always NACKed; elsewhere the level is
            // ignored by the controller, so only reset drives it low.
            ack_in_q <= 1'b1;
            rd_q     <= rd_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdat_q   <= wdat_d;
            nack_q   <= nack_d;
            al_q     <= al_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign nack_err = nack_q;
    assign al_err   = al_q;
    assign rdata    = rdata_q;
    assign start    = cmd_q.start;
    assign stop     = cmd_q.stop;
    assign read     = cmd_q.read;
    assign write    = cmd_q.write;
    assign ack_in   = ack_in_q;
    assign din      = cmd_q.din;

endmodule
